boot_rom_integrity_check: RTL and testbench
===========================================

# boot_rom_integrity_check

Request-path stage placed directly upstream of the boot ROM slave. It passes SoC interconnect TCDM traffic through to the ROM. On command, it takes over the ROM port, reads every ROM word back-to-back and folds the words into a 32-bit signature. It compares the signature against an expected value and reports pass/fail to the SoC control registers before boot code is trusted.

## Interface
- ROM_ADDR_WIDTH, 13: ROM byte-address width; the ROM holds NUM_WORDS = 2^(ROM_ADDR_WIDTH-2) words.
- BASE_ADDR, SOC_MEM_MAP_BOOT_ROM_START_ADDR: bus address of ROM word 0.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that starts a scan.
- expected_i  in  32  reference signature; sampled only at scan end.
- busy_o  out  1  scan in progress.
- done_o  out  1  sticky; signature valid.
- pass_o  out  1  sticky; signature == expected_i.
- signature_o  out  32  final signature.
- slv_req_i / slv_add_i[32] / slv_wen_i / slv_wdata_i[32] / slv_be_i[4]  in: interconnect request.
- slv_gnt_o / slv_r_valid_o / slv_r_rdata_o[32]  out: interconnect response.
- mst_req_o / mst_add_o[32] / mst_wen_o / mst_wdata_o[32] / mst_be_o[4]  out: request to ROM.
- mst_gnt_i / mst_r_valid_i / mst_r_rdata_i[32]  in: ROM response. Fixed 1-cycle read latency.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE/DONE: the bus owns the ROM port. mst_* = slv_*, slv_gnt_o = mst_gnt_i.
- start_i in IDLE or DONE: go to SCAN on the next cycle.
  - Clear acc, addr counter, response counter, done_o and pass_o.
  - Set busy_o.
- start_i in SCAN or DRAIN is ignored.
- SCAN:
  - slv_gnt_o = 0; bus requests stall and are not forwarded.
  - mst_req_o = 1, mst_wen_o = 1 (read), mst_be_o = 4'hF, mst_wdata_o = 0.
  - mst_add_o = BASE_ADDR + 4*addr_cnt. addr_cnt advances only on mst_gnt_i.
  - After word NUM_WORDS-1 is granted, go to DRAIN.
- DRAIN: mst_req_o = 0, slv_gnt_o = 0. Wait until resp_cnt == NUM_WORDS, then go to DONE.
- Signature update, for each scan response: acc <= {acc[30:0], acc[31]} ^ mst_r_rdata_i. Initial acc = 0.
- On entry to DONE:
  - signature_o <= acc; done_o <= 1; pass_o <= (acc == expected_i); busy_o <= 0.
- Response routing uses owner_q, a 1-bit register set to "scan" or "bus" on each granted request.
  - mst_r_valid_i is routed to the engine when owner_q = scan, otherwise to slv_r_valid_o.
  - slv_r_rdata_o = mst_r_rdata_i always.
  - slv_r_valid_o is forced 0 for scan responses.
- Boundary conditions:
  - A bus read granted in the cycle start_i is asserted still returns to the bus next cycle and never enters acc.
  - A bus request and start_i in the same IDLE cycle: the bus request is granted; the scan begins the next cycle.
  - addr_cnt is ROM_ADDR_WIDTH-1 bits wide so it can reach NUM_WORDS with no wrap.
  - Reset asserted mid-scan clears everything; there is no resume.

## Timing
- Reset values: busy_o=0, done_o=0, pass_o=0, signature_o=0, owner_q=bus, state IDLE. mst_req_o follows slv_req_i.
- start_i at cycle 0: first scan request at cycle 1; busy_o=1 from cycle 1.
- With mst_gnt_i tied high: last request at cycle NUM_WORDS, last response at NUM_WORDS+1, done_o=1 at NUM_WORDS+2. Total NUM_WORDS+2 cycles.
- Pass-through is purely combinational; it adds zero latency to bus traffic.

## Structure
- Shared package boot_rom_pkg holds:
  - the state enum;
  - the signature width (32);
  - the rotate-XOR update function, so that software and the bench reuse the same definition.
- The flat slv_*/mst_* ports are bundled into XBAR_TCDM_BUS Slave/Master modports by the SoC wrapper.
- No sub-module; the block is one FSM plus counters.

## Test plan
- Pass-through: with ROM_ADDR_WIDTH=13 and a ROM model holding word[i]=i, a bus read of 0x1A000010 returns r_rdata=4 one cycle after req, with gnt=1.
- Scan pass:
  - Set expected_i to the model's rotate-XOR of words 0..2047, pulse start_i.
  - Required: done_o=1 and pass_o=1 exactly 2050 cycles later, signature_o equal to expected_i, busy_o=0.
- Scan fail: flip bit 0 of word 1000 and rescan. Required: pass_o=0, done_o=1, signature differs by one bit from the good value.
- Bus collision:
  - A bus read is granted in the same cycle as start_i: its response reaches slv_r_valid_o next cycle.
  - A bus request held during the scan sees gnt=0 until DONE, then completes normally.
- Stalling ROM: mst_gnt_i randomly low 50% of cycles. Required: the same signature as the no-stall case and no address skipped.
- Reset mid-scan: rst_ni low at cycle 500 of a scan. Required: all outputs 0; a subsequent start_i produces the correct signature.

Source files
------------

// File: rtl/boot_rom_pkg.sv
// Shared definitions for the boot ROM integrity checker.
//   state_e    : scan controller states
//   SIG_WIDTH  : width of the ROM signature
//   sig_update : one rotate-left-by-1 then XOR fold step of the signature
package boot_rom_pkg;

    localparam int unsigned SIG_WIDTH = 32;
    localparam logic [31:0] SOC_MEM_MAP_BOOT_ROM_START_ADDR = 32'h1A00_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Fold one ROM word into the running signature.
    function automatic logic [SIG_WIDTH-1:0] sig_update(
        input logic [SIG_WIDTH-1:0] acc,
        input logic [SIG_WIDTH-1:0] word
    );
        return {acc[SIG_WIDTH-2:0], acc[SIG_WIDTH-1]} ^ word;
    endfunction

endpackage

// File: rtl/boot_rom_integrity_check.sv
// Request-path stage in front of the boot ROM slave.
// Passes interconnect TCDM traffic through to the ROM; on start_i it takes
// the ROM port, reads every word back-to-back and folds them into a
// signature, then reports done/pass against expected_i.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   start_i                       one-cycle scan start pulse
//   expected_i                    reference signature, sampled at scan end
//   busy_o, done_o, pass_o        scan status (done/pass sticky)
//   signature_o                   final signature
//   slv_*                         interconnect side of the ROM port
//   mst_*                         ROM side (fixed 1-cycle read latency)
module boot_rom_integrity_check
    import boot_rom_pkg::*;
#(
    parameter int unsigned ROM_ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR      = SOC_MEM_MAP_BOOT_ROM_START_ADDR
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [SIG_WIDTH-1:0] expected_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [SIG_WIDTH-1:0] signature_o,
    input  logic                 slv_req_i,
    input  logic [31:0]          slv_add_i,
    input  logic                 slv_wen_i,
    input  logic [31:0]          slv_wdata_i,
    input  logic [3:0]           slv_be_i,
    output logic                 slv_gnt_o,
    output logic                 slv_r_valid_o,
    output logic [31:0]          slv_r_rdata_o,
    output logic                 mst_req_o,
    output logic [31:0]          mst_add_o,
    output logic                 mst_wen_o,
    output logic [31:0]          mst_wdata_o,
    output logic [3:0]           mst_be_o,
    input  logic                 mst_gnt_i,
    input  logic                 mst_r_valid_i,
    input  logic [31:0]          mst_r_rdata_i
);

    // Counters are one bit wider than a word index so they can hold NUM_WORDS.
    localparam int unsigned CNT_W     = ROM_ADDR_WIDTH - 1;
    localparam int unsigned NUM_WORDS = 2 ** (ROM_ADDR_WIDTH - 2);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NUM_WORDS);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_W-1:0]     r_addr_cnt;
    logic [CNT_W-1:0]     r_resp_cnt;
    logic [SIG_WIDTH-1:0] r_acc;
    logic                 r_owner_scan;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [SIG_WIDTH-1:0] r_signature;

    logic                 w_start_scan;
    logic                 w_finish;
    logic                 w_scan_rvalid;
    logic [CNT_W-1:0]     w_resp_cnt_nxt;
    logic [SIG_WIDTH-1:0] w_acc_nxt;

    // Responses follow whoever owned the request granted one cycle earlier.
    assign w_scan_rvalid  = mst_r_valid_i & r_owner_scan;
    assign slv_r_valid_o  = mst_r_valid_i & ~r_owner_scan;
    assign slv_r_rdata_o  = mst_r_rdata_i;
    assign w_resp_cnt_nxt = w_scan_rvalid ? r_resp_cnt + CNT_W'(1) : r_resp_cnt;
    assign w_acc_nxt      = w_scan_rvalid ? sig_update(r_acc, mst_r_rdata_i) : r_acc;

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign signature_o = r_signature;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and ROM port multiplexing.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_scan = 1'b0;
        w_finish     = 1'b0;
        mst_req_o    = slv_req_i;
        mst_add_o    = slv_add_i;
        mst_wen_o    = slv_wen_i;
        mst_wdata_o  = slv_wdata_i;
        mst_be_o     = slv_be_i;
        slv_gnt_o    = mst_gnt_i;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_state_nxt  = ST_SCAN;
                    w_start_scan = 1'b1;
                end
            end
            ST_SCAN: begin
                mst_req_o   = 1'b1;
                mst_add_o   = BASE_ADDR + 32'({r_addr_cnt, 2'b00});
                mst_wen_o   = 1'b1;
                mst_wdata_o = 32'h0;
                mst_be_o    = 4'hF;
                slv_gnt_o   = 1'b0;
                if (mst_gnt_i && (r_addr_cnt == LAST_ADDR)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                mst_req_o   = 1'b0;
                mst_add_o   = BASE_ADDR + 32'({r_addr_cnt, 2'b00});
                mst_wen_o   = 1'b1;
                mst_wdata_o = 32'h0;
                mst_be_o    = 4'hF;
                slv_gnt_o   = 1'b0;
                // Enter DONE as the final response lands so done_o rises the cycle after it.
                if (w_resp_cnt_nxt == CNT_FULL) begin
                    w_state_nxt = ST_DONE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Scan datapath, ownership tracking and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr_cnt   <= '0;
            r_resp_cnt   <= '0;
            r_acc        <= '0;
            r_owner_scan <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_signature  <= '0;
        end else begin
            if (mst_req_o && mst_gnt_i) begin
                r_owner_scan <= (r_state == ST_SCAN);
            end

            if (w_start_scan) begin
                r_addr_cnt <= '0;
                r_resp_cnt <= '0;
                r_acc      <= '0;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
                r_busy     <= 1'b1;
            end else begin
                r_acc      <= w_acc_nxt;
                r_resp_cnt <= w_resp_cnt_nxt;
                if ((r_state == ST_SCAN) && mst_gnt_i) begin
                    r_addr_cnt <= r_addr_cnt + CNT_W'(1);
                end
                if (w_finish) begin
                    r_signature <= w_acc_nxt;
                    r_done      <= 1'b1;
                    r_pass      <= (w_acc_nxt == expected_i);
                    r_busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_rom_integrity_check.sv
// Directed bench for boot_rom_integrity_check with a 2048-word ROM model.
module tb_boot_rom_integrity_check;

    localparam int unsigned NW        = 2048;
    localparam logic [31:0] BASE      = 32'h1A00_0000;
    localparam int          SCAN_CYC  = NW + 2;
    localparam int          LIMIT     = 20000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] expected_i = 32'h0;
    logic        busy_o, done_o, pass_o;
    logic [31:0] signature_o;
    logic        slv_req_i = 1'b0;
    logic [31:0] slv_add_i = 32'h0;
    logic        slv_wen_i = 1'b1;
    logic [31:0] slv_wdata_i = 32'h0;
    logic [3:0]  slv_be_i = 4'hF;
    logic        slv_gnt_o, slv_r_valid_o;
    logic [31:0] slv_r_rdata_o;
    logic        mst_req_o, mst_wen_o;
    logic [31:0] mst_add_o, mst_wdata_o;
    logic [3:0]  mst_be_o;
    logic        mst_gnt_i = 1'b1;
    logic        mst_r_valid_i;
    logic [31:0] mst_r_rdata_i;

    logic [31:0] rom [NW];
    logic        gnt_rand = 1'b0;
    int          scan_idx = 0;
    int          skip_err = 0;
    int          gnt_err  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] good_sig;

    boot_rom_integrity_check #(.ROM_ADDR_WIDTH(13), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .expected_i(expected_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .signature_o(signature_o),
        .slv_req_i(slv_req_i), .slv_add_i(slv_add_i), .slv_wen_i(slv_wen_i),
        .slv_wdata_i(slv_wdata_i), .slv_be_i(slv_be_i), .slv_gnt_o(slv_gnt_o),
        .slv_r_valid_o(slv_r_valid_o), .slv_r_rdata_o(slv_r_rdata_o),
        .mst_req_o(mst_req_o), .mst_add_o(mst_add_o), .mst_wen_o(mst_wen_o),
        .mst_wdata_o(mst_wdata_o), .mst_be_o(mst_be_o), .mst_gnt_i(mst_gnt_i),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_rdata_i(mst_r_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // ROM model: 1-cycle read latency.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mst_r_valid_i <= 1'b0;
            mst_r_rdata_i <= 32'h0;
        end else begin
            mst_r_valid_i <= mst_req_o && mst_gnt_i;
            if (mst_req_o && mst_gnt_i)
                mst_r_rdata_i <= rom[11'((mst_add_o - BASE) >> 2)];
        end
    end

    // ROM grant: tied high or randomly stalled.
    always @(negedge clk_i) begin
        mst_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scan address monitor and bus-stall monitor.
    always @(negedge clk_i) begin
        #2;
        if (!rst_ni || start_i) begin
            scan_idx = 0;
        end else if (busy_o && mst_req_o && mst_gnt_i) begin
            if (mst_add_o !== BASE + 32'(scan_idx) * 4) skip_err++;
            scan_idx++;
        end
        if (busy_o && slv_gnt_o) gnt_err++;
    end

    function automatic logic [31:0] model_sig();
        logic [31:0] a = 32'h0;
        for (int i = 0; i < NW; i++) a = {a[30:0], a[31]} ^ rom[i];
        return a;
    endfunction

    // Pulse start; returns positioned at cycle 1 (#1 after the negedge).
    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
    endtask

    // From cycle 1, count cycles until done_o (bounded).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_o && cyc < LIMIT) begin
            @(negedge clk_i);
            cyc++;
            #1;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
        n_checks++; if (pass_o !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass_o); end
        n_checks++; if (signature_o !== 32'h0) begin n_fail++; $display("FAIL reset_sig got %h want 0", signature_o); end
        slv_req_i = 1'b1;
        #1;
        n_checks++; if (mst_req_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_follow got %b want 1", mst_req_o); end
        slv_req_i = 1'b0;
        #1;
        n_checks++; if (mst_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_follow0 got %b want 0", mst_req_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_passthrough();
        @(negedge clk_i);
        slv_req_i = 1'b1; slv_add_i = 32'h1A00_0010; slv_wen_i = 1'b1;
        #1;
        n_checks++; if (slv_gnt_o !== 1'b1) begin n_fail++; $display("FAIL pt_gnt got %b want 1", slv_gnt_o); end
        n_checks++; if (mst_add_o !== 32'h1A00_0010) begin n_fail++; $display("FAIL pt_addr got %h want 1a000010", mst_add_o); end
        @(negedge clk_i);
        slv_req_i = 1'b0;
        #1;
        n_checks++; if (slv_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL pt_rvalid got %b want 1", slv_r_valid_o); end
        n_checks++; if (slv_r_rdata_o !== 32'd4) begin n_fail++; $display("FAIL pt_rdata got %h want 4", slv_r_rdata_o); end
    endtask

    task automatic test_scan_pass();
        int cyc;
        expected_i = good_sig;
        pulse_start();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL scan_busy1 got %b want 1", busy_o); end
        n_checks++; if (mst_req_o !== 1'b1 || mst_add_o !== BASE) begin n_fail++; $display("FAIL scan_first_req got req=%b addr=%h want 1 %h", mst_req_o, mst_add_o, BASE); end
        wait_done(cyc);
        n_checks++; if (cyc !== SCAN_CYC) begin n_fail++; $display("FAIL scan_latency got %0d want %0d", cyc, SCAN_CYC); end
        n_checks++; if (pass_o !== 1'b1) begin n_fail++; $display("FAIL scan_pass got %b want 1", pass_o); end
        n_checks++; if (signature_o !== good_sig) begin n_fail++; $display("FAIL scan_sig got %h want %h", signature_o, good_sig); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL scan_busy_end got %b want 0", busy_o); end
    endtask

    task automatic test_scan_fail();
        int cyc;
        rom[1000] = rom[1000] ^ 32'h1;
        expected_i = good_sig;
        pulse_start();
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL fail_done_clr got %b want 0", done_o); end
        wait_done(cyc);
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL fail_done got %b want 1", done_o); end
        n_checks++; if (pass_o !== 1'b0) begin n_fail++; $display("FAIL fail_pass got %b want 0", pass_o); end
        // Bit 0 of word 1000 is rotated 1047 times: lands on bit 23.
        n_checks++; if ((signature_o ^ good_sig) !== 32'h0080_0000) begin n_fail++; $display("FAIL fail_sig_diff got %h want 00800000", signature_o ^ good_sig); end
        rom[1000] = rom[1000] ^ 32'h1;
    endtask

    task automatic test_collision();
        int cyc;
        int gerr0;
        expected_i = good_sig;
        gerr0 = gnt_err;
        @(negedge clk_i);
        start_i = 1'b1; slv_req_i = 1'b1; slv_add_i = 32'h1A00_0020; slv_wen_i = 1'b1;
        #1;
        n_checks++; if (slv_gnt_o !== 1'b1) begin n_fail++; $display("FAIL coll_gnt got %b want 1", slv_gnt_o); end
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        n_checks++; if (slv_r_valid_o !== 1'b1 || slv_r_rdata_o !== 32'd8) begin n_fail++; $display("FAIL coll_rsp got v=%b d=%h want 1 8", slv_r_valid_o, slv_r_rdata_o); end
        n_checks++; if (slv_gnt_o !== 1'b0) begin n_fail++; $display("FAIL coll_stall got %b want 0", slv_gnt_o); end
        wait_done(cyc);
        n_checks++; if (gnt_err !== gerr0) begin n_fail++; $display("FAIL coll_gnt_in_scan got %0d want %0d", gnt_err, gerr0); end
        n_checks++; if (slv_gnt_o !== 1'b1) begin n_fail++; $display("FAIL coll_gnt_done got %b want 1", slv_gnt_o); end
        n_checks++; if (pass_o !== 1'b1 || signature_o !== good_sig) begin n_fail++; $display("FAIL coll_sig got %h pass=%b want %h 1", signature_o, pass_o, good_sig); end
        @(negedge clk_i);
        slv_req_i = 1'b0;
        #1;
        n_checks++; if (slv_r_valid_o !== 1'b1 || slv_r_rdata_o !== 32'd8) begin n_fail++; $display("FAIL coll_late_rsp got v=%b d=%h want 1 8", slv_r_valid_o, slv_r_rdata_o); end
    endtask

    task automatic test_stall();
        int cyc;
        int serr0;
        expected_i = good_sig;
        serr0 = skip_err;
        gnt_rand = 1'b1;
        pulse_start();
        wait_done(cyc);
        gnt_rand = 1'b0;
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b want 1 after %0d cycles", done_o, cyc); end
        n_checks++; if (signature_o !== good_sig || pass_o !== 1'b1) begin n_fail++; $display("FAIL stall_sig got %h pass=%b want %h 1", signature_o, pass_o, good_sig); end
        n_checks++; if (skip_err !== serr0) begin n_fail++; $display("FAIL stall_addr_seq got %0d errs want %0d", skip_err, serr0); end
        n_checks++; if (scan_idx !== NW) begin n_fail++; $display("FAIL stall_grants got %0d want %0d", scan_idx, NW); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        expected_i = good_sig;
        pulse_start();
        repeat (499) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_status got b=%b d=%b p=%b want 0 0 0", busy_o, done_o, pass_o); end
        n_checks++; if (signature_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_sig got %h want 0", signature_o); end
        n_checks++; if (mst_req_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req got %b want 0", mst_req_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        pulse_start();
        wait_done(cyc);
        n_checks++; if (cyc !== SCAN_CYC) begin n_fail++; $display("FAIL mid_rescan_latency got %0d want %0d", cyc, SCAN_CYC); end
        n_checks++; if (signature_o !== good_sig || pass_o !== 1'b1) begin n_fail++; $display("FAIL mid_rescan_sig got %h pass=%b want %h 1", signature_o, pass_o, good_sig); end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) rom[i] = 32'(i);
        good_sig = model_sig();
        test_reset();
        test_passthrough();
        test_scan_pass();
        test_scan_fail();
        test_collision();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
